// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit stream.
//             tx_state_t      - transmitter FSM states
//             UART_DATA_BITS  - payload bits per frame
//             UART_FRAME_BITS - start + data + stop bits per frame
//             UART_IDLE_LEVEL - level of the serial line between frames
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync_fifo
//  Purpose  : Single-clock FIFO with a registered occupancy count.
//  Ports    : clk, resetn (async, active-low)
//             push/wdata  - write request; ignored while full
//             pop         - read request; ignored while empty
//             rdata       - head entry, valid while !empty
//             level       - registered number of stored entries
//             full, empty - decoded from level
//  Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // The level carries one extra bit so full (== DEPTH) and empty (== 0)
  // stay distinct even though the pointers alias after a wrap.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so natural overflow gives modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible through level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_stream
//  Purpose  : 8N1 LSB-first UART transmitter fed by a valid/ready byte
//             stream through a small FIFO; back-to-back frames leave no gap.
//  Ports    : clk, resetn (async, active-low)
//             in_valid/in_ready/in_data - byte stream input (ready = !full)
//             ser_tx     - registered serial line, idle high
//             busy       - registered, high while a frame is on the line
//             fifo_level - registered count of queued bytes
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("uart_tx_stream: FIFO_DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ser_tx_q, ser_tx_d;
  logic          busy_q, busy_d;

  logic          fifo_pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          bit_done;

  assign in_ready = !fifo_full;
  assign ser_tx   = ser_tx_q;
  assign busy     = busy_q;
  assign bit_done = (clk_cnt_q == CNT_LAST);

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_valid && in_ready),
    .pop    (fifo_pop),
    .wdata  (in_data),
    .rdata  (fifo_rdata),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Line and busy are computed one cycle ahead so that they change on the
  // same edge as the state they belong to.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ser_tx_d  = ser_tx_q;
    busy_d    = busy_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        ser_tx_d  = UART_IDLE_LEVEL;
        busy_d    = 1'b0;
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = START;
          ser_tx_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          ser_tx_d  = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            state_d  = STOP;
            ser_tx_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            ser_tx_d  = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = START;
            ser_tx_d = 1'b0;
          end else begin
            state_d  = IDLE;
            ser_tx_d = UART_IDLE_LEVEL;
            busy_d   = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        ser_tx_d = UART_IDLE_LEVEL;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ser_tx_q  <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ser_tx_q  <= ser_tx_d;
      busy_q    <= busy_d;
    end
  end

endmodule : uart_tx_stream
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_stream
//  Purpose  : Self-checking bench for uart_tx_stream. Line, busy, level and
//             ready are logged once per cycle; each scenario task drives the
//             stream and compares the log against frames computed from the
//             8N1 rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int CPB   = 5;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int HMAX  = 8192;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       ser_tx;
  logic       busy;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       hist_tx   [HMAX];
  logic       hist_busy [HMAX];
  logic       hist_rdy  [HMAX];
  logic [2:0] hist_lvl  [HMAX];

  logic [7:0] dec_q[$];
  int         dec_ferr;

  uart_tx_stream #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; entry i holds the values seen
  // between rising edge i and rising edge i+1.
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      hist_tx[cyc]   = ser_tx;
      hist_busy[cyc] = busy;
      hist_rdy[cyc]  = in_ready;
      hist_lvl[cyc]  = fifo_level;
    end
  end

  // Expected line level k cycles into a frame carrying byte b.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int bit_no;
    bit_no = k / CPB;
    if (bit_no == 0)      return 1'b0;
    else if (bit_no <= 8) return b[bit_no-1];
    else                  return 1'b1;
  endfunction

  function automatic int frame_diff(input int s, input logic [7:0] b);
    int n;
    n = 0;
    for (int k = 0; k < FRAME; k++)
      if (hist_tx[s+k] !== exp_line(b, k)) n++;
    return n;
  endfunction

  function automatic int count_busy_low(input int s, input int n);
    int z;
    z = 0;
    for (int k = 0; k < n; k++)
      if (hist_busy[s+k] !== 1'b1) z++;
    return z;
  endfunction

  task automatic wait_idx(input int idx);
    int k;
    k = 0;
    while (cyc <= idx && k < HMAX) begin
      @(negedge clk);
      k++;
    end
    if (cyc <= idx) begin
      total++; bad++;
      $display("FAIL wait_idx: cycle=%0d required_past=%0d", cyc, idx);
    end
  endtask

  // Generic UART receiver over the logged line: finds start bits, requires
  // every bit to be stable for its full period and the stop bit high.
  task automatic decode(input int s, input int t);
    int         i;
    logic [7:0] b;
    logic       lvl;
    dec_q.delete();
    dec_ferr = 0;
    i = s;
    while (i < t) begin
      if (hist_tx[i] === 1'b0) begin
        if (i + FRAME > t) begin
          dec_ferr++;
          break;
        end
        for (int j = 0; j < 10; j++) begin
          lvl = hist_tx[i + j*CPB + CPB/2];
          for (int k = 0; k < CPB; k++)
            if (hist_tx[i + j*CPB + k] !== lvl) dec_ferr++;
          if (j == 0 && lvl !== 1'b0) dec_ferr++;
          if (j == 9 && lvl !== 1'b1) dec_ferr++;
          if (j >= 1 && j <= 8) b[j-1] = lvl;
        end
        dec_q.push_back(b);
        i = i + FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ser_tx !== 1'b1)        begin bad++; $display("FAIL reset_ser_tx: got=%b exp=1", ser_tx); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    total++; if (fifo_level !== 3'd0)    begin bad++; $display("FAIL reset_level: got=%0d exp=0", fifo_level); end
    total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL reset_ready: got=%b exp=1", in_ready); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ser_tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: ser_tx=%b busy=%b exp 1/0", ser_tx, busy);
    end
  endtask

  task automatic test_single_byte;
    int e, n;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h0A;
    @(negedge clk);
    e = cyc;
    in_valid = 1'b0;
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level_after_push: got=%0d exp=1", fifo_level); end
    total++; if (ser_tx !== 1'b1)     begin bad++; $display("FAIL single_line_on_accept: got=%b exp=1", ser_tx); end
    wait_idx(e + FRAME + 2);
    n = frame_diff(e + 1, 8'h0A);
    total++; if (n !== 0) begin bad++; $display("FAIL single_frame: bad_samples=%0d exp=0", n); end
    n = count_busy_low(e + 1, FRAME);
    total++; if (n !== 0) begin bad++; $display("FAIL single_busy_high: low_cycles=%0d exp=0", n); end
    total++; if (hist_busy[e] !== 1'b0 || hist_busy[e+1+FRAME] !== 1'b0) begin
      bad++; $display("FAIL single_busy_edges: before=%b after=%b exp 0/0", hist_busy[e], hist_busy[e+1+FRAME]);
    end
    total++; if (hist_tx[e+1+FRAME] !== 1'b1 || hist_lvl[e+1] !== 3'd0) begin
      bad++; $display("FAIL single_tail: line=%b level_after_pop=%0d exp 1/0", hist_tx[e+1+FRAME], hist_lvl[e+1]);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] msg [3];
    int e, nrdy, nbad;
    msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A;
    e = 0; nrdy = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = msg[i];
      if (in_ready !== 1'b1) nrdy++;
      @(negedge clk);
      if (i == 0) e = cyc;
    end
    in_valid = 1'b0;
    total++; if (nrdy !== 0) begin bad++; $display("FAIL loopback_ready: not_ready=%0d exp=0", nrdy); end
    wait_idx(e + 1 + 3*FRAME + 4);
    decode(e, e + 1 + 3*FRAME + 4);
    nbad = 0;
    if (dec_q.size() == 3) begin
      for (int i = 0; i < 3; i++) if (dec_q[i] !== msg[i]) nbad++;
    end
    total++; if (dec_q.size() !== 3 || nbad !== 0 || dec_ferr !== 0) begin
      bad++; $display("FAIL loopback_decode: bytes=%0d wrong=%0d framing=%0d exp 3/0/0", dec_q.size(), nbad, dec_ferr);
    end
  endtask

  task automatic test_burst;
    logic [7:0] pat [5];
    int e, n, nrdy;
    pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'h00; pat[3] = 8'hFF; pat[4] = 8'h31;
    e = 0; nrdy = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = pat[i];
      if (in_ready !== 1'b1) nrdy++;
      @(negedge clk);
      if (i == 0) e = cyc;
    end
    in_valid = 1'b0;
    total++; if (nrdy !== 0) begin bad++; $display("FAIL burst_ready: not_ready=%0d exp=0", nrdy); end
    wait_idx(e + 1 + 5*FRAME + 1);
    for (int f = 0; f < 5; f++) begin
      n = frame_diff(e + 1 + f*FRAME, pat[f]);
      total++; if (n !== 0) begin bad++; $display("FAIL burst_frame%0d: bad_samples=%0d exp=0", f, n); end
    end
    n = count_busy_low(e + 1, 5*FRAME);
    total++; if (n !== 0) begin bad++; $display("FAIL burst_busy: low_cycles=%0d exp=0", n); end
    total++; if (hist_busy[e+1+5*FRAME] !== 1'b0 || hist_tx[e+1+5*FRAME] !== 1'b1) begin
      bad++; $display("FAIL burst_end: busy=%b line=%b exp 0/1", hist_busy[e+1+5*FRAME], hist_tx[e+1+5*FRAME]);
    end
  endtask

  task automatic test_full_fifo;
    logic [7:0] pat [6];
    int e, acc, n, nrdy;
    pat[0] = 8'h11; pat[1] = 8'h55; pat[2] = 8'hAA; pat[3] = 8'h00; pat[4] = 8'hFF; pat[5] = 8'h31;
    e = 0; nrdy = 0; acc = -1;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = pat[i];
      if (in_ready !== 1'b1) nrdy++;
      @(negedge clk);
      if (i == 0) e = cyc;
    end
    in_data = pat[5];
    total++; if (nrdy !== 0) begin bad++; $display("FAIL full_ready_before: not_ready=%0d exp=0", nrdy); end
    total++; if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_state: level=%0d ready=%b exp 4/0", fifo_level, in_ready);
    end
    for (int k = 0; k < 4*FRAME; k++) begin
      if (in_ready === 1'b1) begin
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    // The first frame's stop ends at edge e+51 (pop), freeing one slot.
    total++; if (acc !== e + FRAME + 2) begin bad++; $display("FAIL full_held_accept_edge: got=%0d exp=%0d", acc, e + FRAME + 2); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level_refill: got=%0d exp=4", fifo_level); end
    wait_idx(e + 1 + 6*FRAME + 1);
    n = 0;
    for (int i = e; i < e + 1 + 6*FRAME; i++) begin
      if (hist_lvl[i] > 3'd4) n++;
      if (hist_rdy[i] !== (hist_lvl[i] != 3'd4)) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL full_level_ready_rule: violations=%0d exp=0", n); end
    for (int f = 0; f < 6; f++) begin
      n = frame_diff(e + 1 + f*FRAME, pat[f]);
      total++; if (n !== 0) begin bad++; $display("FAIL full_frame%0d: bad_samples=%0d exp=0", f, n); end
    end
  endtask

  task automatic test_simul_push_pop;
    logic [7:0] pat [4];
    int e, n, k;
    pat[0] = 8'hC3; pat[1] = 8'h5A; pat[2] = 8'h96; pat[3] = 8'h7E;
    e = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = pat[i];
      @(negedge clk);
      if (i == 0) e = cyc;
    end
    in_valid = 1'b0;
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL simul_level_before: got=%0d exp=2", fifo_level); end
    k = 0;
    while (cyc < e + FRAME && k < 4*FRAME) begin
      @(negedge clk);
      k++;
    end
    // Next rising edge is the stop-to-start pop of the second byte.
    in_valid = 1'b1; in_data = pat[3];
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (fifo_level !== 3'd2 || hist_lvl[e+FRAME] !== 3'd2) begin
      bad++; $display("FAIL simul_level_after: got=%0d before=%0d exp 2/2", fifo_level, hist_lvl[e+FRAME]);
    end
    wait_idx(e + 1 + 4*FRAME + 1);
    n = 0;
    for (int f = 0; f < 4; f++) n += frame_diff(e + 1 + f*FRAME, pat[f]);
    total++; if (n !== 0) begin bad++; $display("FAIL simul_order_frames: bad_samples=%0d exp=0", n); end
  endtask

  task automatic test_reset_mid_frame;
    int e, e2, n, k;
    e = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hA5; @(negedge clk); e = cyc;
    in_data = 8'h01; @(negedge clk);
    in_data = 8'h02; @(negedge clk);
    in_valid = 1'b0;
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL rstmid_queued: got=%0d exp=2", fifo_level); end
    k = 0;
    while (cyc < e + 1 + 4*CPB + 1 && k < 4*FRAME) begin
      @(negedge clk);
      k++;
    end
    // Data bit 3 of 0xA5 is 0, so a reset must visibly pull the line high.
    total++; if (ser_tx !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_bit3: line=%b busy=%b exp 0/1", ser_tx, busy);
    end
    #2 resetn = 1'b0;
    #1;
    total++; if (ser_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_async: line=%b busy=%b level=%0d ready=%b exp 1/0/0/1", ser_tx, busy, fifo_level, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ser_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL rstmid_quiet: line=%b busy=%b level=%0d exp 1/0/0", ser_tx, busy, fifo_level);
    end
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    e2 = cyc;
    in_valid = 1'b0;
    wait_idx(e2 + 1 + FRAME + 2*CPB);
    n = frame_diff(e2 + 1, 8'h3C);
    for (int i = e2 + 1 + FRAME; i < e2 + 1 + FRAME + 2*CPB; i++)
      if (hist_tx[i] !== 1'b1 || hist_busy[i] !== 1'b0) n++;
    total++; if (n !== 0) begin bad++; $display("FAIL rstmid_clean_frame: bad_samples=%0d exp=0", n); end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int s, w, nbad, k;
    exp_q.delete();
    @(negedge clk);
    s = cyc;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b = 8'($urandom);
      in_valid = 1'b1; in_data = b;
      w = 0;
      while (in_ready !== 1'b1 && w < 4*FRAME) begin
        @(negedge clk);
        w++;
      end
      if (w >= 4*FRAME) begin
        total++; bad++;
        $display("FAIL random_ready_timeout: waited=%0d limit=%0d", w, 4*FRAME);
        in_valid = 1'b0;
        break;
      end
      @(negedge clk);
      exp_q.push_back(b);
      in_valid = 1'b0;
    end
    k = 0;
    while ((busy !== 1'b0 || fifo_level !== 3'd0) && k < 20*FRAME) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0 || fifo_level !== 3'd0) begin
      bad++; $display("FAIL random_drain: busy=%b level=%0d exp 0/0", busy, fifo_level);
    end
    decode(s, cyc - 1);
    nbad = 0;
    if (dec_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) if (dec_q[i] !== exp_q[i]) nbad++;
    end
    total++; if (dec_q.size() !== exp_q.size() || nbad !== 0 || dec_ferr !== 0) begin
      bad++; $display("FAIL random_stream: bytes=%0d exp_bytes=%0d wrong=%0d framing=%0d", dec_q.size(), exp_q.size(), nbad, dec_ferr);
    end
    nbad = 0;
    for (int i = s; i < cyc - 1; i++) begin
      if (hist_rdy[i] !== (hist_lvl[i] != 3'd4)) nbad++;
      if (hist_lvl[i] > 3'd4) nbad++;
    end
    total++; if (nbad !== 0) begin bad++; $display("FAIL random_level_ready_rule: violations=%0d exp=0", nbad); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_loopback();
    test_burst();
    test_full_fifo();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_stream
`default_nettype wire
